// File: rtl/dmem_addr_gen.sv
// dmem_addr_gen: strided address generator behind the DMem lane request arbiter.
// It latches the granted lane's base, stride and length. It then issues one
// address per valid/ready handshake. At the end it pulses the owning lane's
// term input so that the arbiter releases the grant.
// Optional build macro: DMEM_AGEN_WRAP_CHK_EN adds O_Err. With the macro defined,
// an address that would carry out of ADDR_W bits aborts the access.
module dmem_addr_gen #(
  parameter int ADDR_W   = 10,
  parameter int STRIDE_W = 10
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [1:0]          I_GrantNo,
  input  logic [ADDR_W-1:0]   I_Length,
  input  logic [STRIDE_W-1:0] I_Stride,
  input  logic [ADDR_W-1:0]   I_Base_Addr,
  input  logic                I_Ready,
  output logic                O_Vld,
  output logic [ADDR_W-1:0]   O_Addr,
  output logic [1:0]          O_LaneNo,
  output logic                O_Term1,
  output logic                O_Term2,
  output logic                O_Term3,
  output logic                O_Busy
`ifdef DMEM_AGEN_WRAP_CHK_EN
  ,
  output logic                O_Err
`endif
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_TERM    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic [1:0]          r_lane;
  logic [ADDR_W-1:0]   r_curAddr;
  logic [ADDR_W-1:0]   r_stride;
  logic [ADDR_W-1:0]   r_remain;

  logic                w_start;
  logic                w_handshake;
  logic                w_lastBeat;
  logic                w_abort;
  logic [ADDR_W-1:0]   w_strideExt;
  logic [ADDR_W-1:0]   w_nextAddr;

  // The stride is brought to address width once, at latch time. Zero-extension
  // is used because the stride is unsigned. Any bits above ADDR_W are dropped.
  assign w_strideExt = ADDR_W'(I_Stride);

  assign w_start     = (r_state == S_IDLE) && (I_GrantNo != 2'b00);
  assign w_handshake = (r_state == S_RUN) && I_Ready;
  assign w_lastBeat  = (r_remain == ADDR_W'(1));

`ifdef DMEM_AGEN_WRAP_CHK_EN
  logic w_carry;
  logic r_err;

  // The carry out of the address add flags a wrap. A wrap only matters if
  // more beats would follow it.
  assign {w_carry, w_nextAddr} = {1'b0, r_curAddr} + {1'b0, r_stride};
  assign w_abort = w_handshake && w_carry && (r_remain > ADDR_W'(1));

  // The error flag is set by an abort. It stays sticky until the next accepted start.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_err <= 1'b0;
    end else if (w_start) begin
      r_err <= 1'b0;
    end else if (w_abort) begin
      r_err <= 1'b1;
    end
  end

  assign O_Err = r_err;
`else
  // Without the check, addresses wrap silently modulo 2^ADDR_W.
  assign w_nextAddr = r_curAddr + r_stride;
  assign w_abort    = 1'b0;
`endif

  // State register. An asynchronous reset drops any access in flight, and no
  // term pulse is issued for it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic. RELEASE waits for the arbiter to drop the old grant, so a
  // stale grant is never taken as a new start.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_nextState = (I_Length == '0) ? S_TERM : S_RUN;
        end
      end
      S_RUN: begin
        if (w_handshake && (w_lastBeat || w_abort)) begin
          w_nextState = S_TERM;
        end
      end
      S_TERM: begin
        w_nextState = S_RELEASE;
      end
      S_RELEASE: begin
        if (I_GrantNo != r_lane) begin
          w_nextState = S_IDLE;
        end
      end
      default: begin
        w_nextState = S_IDLE;
      end
    endcase
  end

  // Access context. Lane, base, stride and length are captured only on the
  // start edge, so later input changes cannot disturb a running access.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_lane    <= 2'b00;
      r_curAddr <= '0;
      r_stride  <= '0;
      r_remain  <= '0;
    end else if (w_start) begin
      r_lane    <= I_GrantNo;
      r_curAddr <= I_Base_Addr;
      r_stride  <= w_strideExt;
      r_remain  <= I_Length;
    end else if (w_handshake) begin
      r_curAddr <= w_nextAddr;
      r_remain  <= r_remain - ADDR_W'(1);
    end
  end

  // The outputs decode directly from registered state. They are glitch-free,
  // and they fall to zero as soon as reset asserts.
  assign O_Vld    = (r_state == S_RUN);
  assign O_Addr   = O_Vld ? r_curAddr : '0;
  assign O_LaneNo = r_lane;
  assign O_Term1  = (r_state == S_TERM) && (r_lane == 2'b01);
  assign O_Term2  = (r_state == S_TERM) && (r_lane == 2'b10);
  assign O_Term3  = (r_state == S_TERM) && (r_lane == 2'b11);
  assign O_Busy   = (r_state != S_IDLE);

endmodule

// File: tb/tb_dmem_addr_gen.sv
// tb_dmem_addr_gen: directed scoreboard bench for dmem_addr_gen.
// It honours the DMEM_AGEN_WRAP_CHK_EN build macro in the same way as the design.
module tb_dmem_addr_gen;

  localparam int AW = 10;
  localparam int SW = 10;

  logic          clock;
  logic          reset;
  logic [1:0]    I_GrantNo;
  logic [AW-1:0] I_Length;
  logic [SW-1:0] I_Stride;
  logic [AW-1:0] I_Base_Addr;
  logic          I_Ready;
  logic          O_Vld;
  logic [AW-1:0] O_Addr;
  logic [1:0]    O_LaneNo;
  logic          O_Term1;
  logic          O_Term2;
  logic          O_Term3;
  logic          O_Busy;
`ifdef DMEM_AGEN_WRAP_CHK_EN
  logic          O_Err;
`endif

  int            checks = 0;
  int            errors = 0;
  logic [AW-1:0] expQ[$];
  logic [1:0]    expLane;
  logic          expErr;

  dmem_addr_gen #(.ADDR_W(AW), .STRIDE_W(SW)) dut (
    .clock       (clock),
    .reset       (reset),
    .I_GrantNo   (I_GrantNo),
    .I_Length    (I_Length),
    .I_Stride    (I_Stride),
    .I_Base_Addr (I_Base_Addr),
    .I_Ready     (I_Ready),
    .O_Vld       (O_Vld),
    .O_Addr      (O_Addr),
    .O_LaneNo    (O_LaneNo),
    .O_Term1     (O_Term1),
    .O_Term2     (O_Term2),
    .O_Term3     (O_Term3),
    .O_Busy      (O_Busy)
`ifdef DMEM_AGEN_WRAP_CHK_EN
    ,
    .O_Err       (O_Err)
`endif
  );

  // Free-running clock with a 10 ns period.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [2:0] termMask(input logic [1:0] lane);
    case (lane)
      2'b01:   return 3'b001;
      2'b10:   return 3'b010;
      2'b11:   return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive a grant, then load the scoreboard with the address sequence the access should produce.
  task automatic applyStimulus(input logic [1:0] grant, input logic [AW-1:0] base,
                               input logic [SW-1:0] stride, input logic [AW-1:0] len);
    logic [AW-1:0] a;
    logic [AW:0]   sum;
    I_GrantNo   = grant;
    I_Base_Addr = base;
    I_Stride    = stride;
    I_Length    = len;
    expLane     = grant;
    expErr      = 1'b0;
    expQ.delete();
    a = base;
    for (int i = 0; i < int'(len); i++) begin
      expQ.push_back(a);
      sum = {1'b0, a} + {1'b0, AW'(stride)};
`ifdef DMEM_AGEN_WRAP_CHK_EN
      if (sum[AW] && (int'(len) - i) > 1) begin
        expErr = 1'b1;
        break;
      end
`endif
      a = sum[AW-1:0];
    end
  endtask

  // Called just before the start edge. The task scrambles the latched inputs,
  // then pops addresses as they are handshaken. It returns on the term-pulse cycle.
  task automatic serviceAccess(input logic [1:0] midGrant, input int stallFirst);
    int stalls;
    bit expectTerm;
    bit done;
    stalls = stallFirst;
    done   = 1'b0;
    @(negedge clock);
    I_GrantNo   = midGrant;
    I_Base_Addr = AW'($urandom);
    I_Stride    = SW'($urandom);
    I_Length    = AW'($urandom);
    expectTerm  = (expQ.size() == 0);
    for (int cyc = 0; cyc < 64 && !done; cyc++) begin
      if (cyc > 0) @(negedge clock);
      if (expectTerm) begin
        checkOutput("term_vld", 32'(O_Vld), 32'(0));
        checkOutput("term_pulse", 32'({O_Term3, O_Term2, O_Term1}), 32'(termMask(expLane)));
        checkOutput("term_busy", 32'(O_Busy), 32'(1));
`ifdef DMEM_AGEN_WRAP_CHK_EN
        checkOutput("term_err", 32'(O_Err), 32'(expErr));
`endif
        done = 1'b1;
      end else begin
        checkOutput("run_vld", 32'(O_Vld), 32'(1));
        checkOutput("run_addr", 32'(O_Addr), 32'(expQ[0]));
        checkOutput("run_lane", 32'(O_LaneNo), 32'(expLane));
        checkOutput("run_noterm", 32'({O_Term3, O_Term2, O_Term1}), 32'(0));
        if (stalls > 0) begin
          I_Ready = 1'b0;
          stalls--;
        end else begin
          I_Ready = 1'b1;
          void'(expQ.pop_front());
          if (expQ.size() == 0) expectTerm = 1'b1;
        end
      end
    end
    checkOutput("service_timeout", 32'(done), 32'(1));
    I_Ready = 1'b1;
  endtask

  // Starting at the term cycle, the task checks the RELEASE state. It then drops
  // the grant and checks that the FSM is back in IDLE.
  task automatic finishRelease();
    @(negedge clock);
    checkOutput("rel_busy", 32'(O_Busy), 32'(1));
    checkOutput("rel_vld", 32'(O_Vld), 32'(0));
    checkOutput("rel_noterm", 32'({O_Term3, O_Term2, O_Term1}), 32'(0));
    I_GrantNo = 2'b00;
    @(negedge clock);
    checkOutput("idle_busy", 32'(O_Busy), 32'(0));
    checkOutput("idle_vld", 32'(O_Vld), 32'(0));
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_vld"}, 32'(O_Vld), 32'(0));
    checkOutput({tag, "_addr"}, 32'(O_Addr), 32'(0));
    checkOutput({tag, "_lane"}, 32'(O_LaneNo), 32'(0));
    checkOutput({tag, "_term"}, 32'({O_Term3, O_Term2, O_Term1}), 32'(0));
    checkOutput({tag, "_busy"}, 32'(O_Busy), 32'(0));
`ifdef DMEM_AGEN_WRAP_CHK_EN
    checkOutput({tag, "_err"}, 32'(O_Err), 32'(0));
`endif
  endtask

  // Directed test sequence.
  initial begin
    reset       = 1'b0;
    I_GrantNo   = 2'b00;
    I_Length    = '0;
    I_Stride    = '0;
    I_Base_Addr = '0;
    I_Ready     = 1'b1;

    @(negedge clock);
    @(negedge clock);
    checkAllZero("reset");
    reset = 1'b1;
    @(negedge clock);

    $display("[TB] basic run, lane 1");
    applyStimulus(2'b01, 10'h010, 10'd4, 10'd3);
    serviceAccess(2'b01, 0);

    $display("[TB] release hold, grant kept at lane 1");
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      checkOutput("hold_busy", 32'(O_Busy), 32'(1));
      checkOutput("hold_vld", 32'(O_Vld), 32'(0));
      checkOutput("hold_noterm", 32'({O_Term3, O_Term2, O_Term1}), 32'(0));
    end

    $display("[TB] stall run, lane 2, with lane change mid-run");
    applyStimulus(2'b10, 10'h100, 10'd1, 10'd2);
    @(negedge clock);
    checkOutput("reidle_busy", 32'(O_Busy), 32'(0));
    serviceAccess(2'b11, 3);
    finishRelease();

    $display("[TB] zero length, lane 3");
    applyStimulus(2'b11, 10'h123, 10'd5, 10'd0);
    serviceAccess(2'b11, 0);
    finishRelease();

    $display("[TB] address wrap, lane 1");
    applyStimulus(2'b01, 10'h3FE, 10'd3, 10'd2);
    serviceAccess(2'b01, 0);
    finishRelease();

    $display("[TB] random small access, lane 3");
    applyStimulus(2'b11, AW'($urandom), SW'($urandom_range(0, 15)), AW'($urandom_range(1, 6)));
    serviceAccess(2'b11, 0);
    finishRelease();

    $display("[TB] reset mid-run, lane 1");
    applyStimulus(2'b01, 10'h200, 10'd2, 10'd5);
    @(negedge clock);
    checkOutput("mid_addr0", 32'(O_Addr), 32'h200);
    @(negedge clock);
    checkOutput("mid_addr1", 32'(O_Addr), 32'h202);
    @(posedge clock);
    #2 reset = 1'b0;
    #1 checkAllZero("midreset");
    I_GrantNo = 2'b00;
    @(negedge clock);
    checkOutput("midreset_noterm", 32'({O_Term3, O_Term2, O_Term1}), 32'(0));
    reset = 1'b1;
    @(negedge clock);
    checkAllZero("postreset");

    $display("[TB] fresh grant after reset, lane 2");
    applyStimulus(2'b10, 10'h050, 10'd7, 10'd3);
    serviceAccess(2'b10, 0);
    finishRelease();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
